// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// FSM encoding and default sizes used by ifetch_queue and ifq_fifo.
package ifetch_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int INST_W = 32;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_REQ  = 2'd1;
  localparam state_t S_DROP = 2'd2;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO of {pc, inst} pairs feeding decode.
// Clear wins over push and pop in the same cycle.
module ifq_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [INST_W-1:0] wr_inst,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [INST_W-1:0] rd_inst
);

  logic [ADDR_W-1:0] pcs   [DEPTH];
  logic [INST_W-1:0] insts [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~clear & ~full;
  assign do_pop  = pop & ~clear & ~empty;
  assign rd_pc   = pcs[rd_ptr];
  assign rd_inst = insts[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pcs[i]   <= '0;
        insts[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pcs[wr_ptr]   <= wr_pc;
        insts[wr_ptr] <= wr_inst;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: PC handshake, one-deep memory request FSM, decode FIFO.
// A flushed in-flight request is kept alive in DROP until its ack arrives.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [INST_W-1:0] mem_data_i,
  output logic              inst_valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_pc_o,
  input  logic              inst_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic          accept;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fill;

  assign accept = start_i & ~flush_i & (state == S_IDLE)
                & (fill < CW'(DEPTH));
  assign stall_o = ~accept;

  assign push = (state == S_REQ) & mem_ack_i & ~flush_i & ~full;
  assign pop  = inst_valid_o & inst_ready_i & ~flush_i;

  assign inst_valid_o = ~empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            mem_addr_o <= pc_i;
            mem_req_o  <= 1'b1;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= S_IDLE;
          end else if (flush_i) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

  ifq_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk_i),
    .rst     (rst_i),
    .push    (push),
    .pop     (pop),
    .clear   (flush_i),
    .wr_pc   (mem_addr_o),
    .wr_inst (mem_data_i),
    .full    (full),
    .empty   (empty),
    .count   (fill),
    .rd_pc   (inst_pc_o),
    .rd_inst (inst_o)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios then random traffic,
// compared every cycle against a queue-based reference model.
module tb_ifetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] pc_i;
  logic        stall_o;
  logic        flush_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_data_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          infl;
  bit          drop;
  logic [31:0] maddr;
  logic [31:0] pc;
  logic [31:0] tgt;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .pc_i         (pc_i),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_ack_i    (mem_ack_i),
    .mem_data_i   (mem_data_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .inst_pc_o    (inst_pc_o),
    .inst_ready_i (inst_ready_i)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle from a negedge, check, then advance the model.
  task automatic step(input bit r, input bit st, input bit fl,
                      input bit ak, input bit rdy);
    bit exp_acc;
    bit do_ack;
    rst_i        = r;
    start_i      = st;
    pc_i         = pc;
    flush_i      = fl;
    mem_ack_i    = ak & infl;
    mem_data_i   = (ak & infl) ? memf(maddr) : 32'h0;
    inst_ready_i = rdy;
    exp_acc = st && !fl && !infl && (q.size() < DEPTH);
    #1;
    chk("stall", {31'b0, stall_o}, {31'b0, !exp_acc});
    chk("req", {31'b0, mem_req_o}, {31'b0, infl});
    if (infl) chk("addr", mem_addr_o, maddr);
    chk("valid", {31'b0, inst_valid_o}, {31'b0, q.size() > 0});
    if (q.size() > 0) begin
      chk("inst_pc", inst_pc_o, q[0].a);
      chk("inst", inst_o, q[0].d);
    end
    @(posedge clk);
    if (r) begin
      q.delete();
      infl = 0;
      drop = 0;
    end else begin
      do_ack = infl && ak;
      if (fl) begin
        q.delete();
      end else begin
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (do_ack && !drop) q.push_back('{a: maddr, d: memf(maddr)});
      end
      if (do_ack) begin
        infl = 0;
        drop = 0;
      end else if (infl && fl) begin
        drop = 1;
      end
      if (exp_acc) begin
        infl  = 1;
        maddr = pc;
        pc    = pc + 32'd4;
      end
      if (fl) pc = tgt;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    pc_i         = '0;
    flush_i      = 1'b0;
    mem_ack_i    = 1'b0;
    mem_data_i   = '0;
    inst_ready_i = 1'b0;
    pc    = '0;
    tgt   = 32'h100;
    infl  = 0;
    drop  = 0;
    maddr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("rst_stall", {31'b0, stall_o}, 32'd1);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_addr", mem_addr_o, 32'd0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);
    @(negedge clk);
    step(0, 0, 0, 0, 1);

    // straight line, zero-wait memory, decode always ready
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 1);
      step(0, 1, 0, 1, 1);
    end
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // three-cycle memory latency at 0x10
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // decode stalled until the queue fills
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 1, 0);
    end
    repeat (3) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    repeat (6) step(0, 0, 0, 0, 1);

    // flush while 0x20 is pending; branch target 0x100
    pc  = 32'h20;
    tgt = 32'h100;
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 1);
    step(0, 0, 0, 0, 1);

    // flush coinciding with ack and pop
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    tgt = 32'h200;
    step(0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1);

    // reset while a request is outstanding
    step(0, 1, 0, 0, 1);
    step(1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0)
        tgt = {$urandom_range(32'hFFFF), 2'b00};
      step(0,
           $urandom_range(7) != 0,
           $urandom_range(19) == 0,
           $urandom_range(2) == 0,
           $urandom_range(3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
